// File: rtl/sirc_user_port_responder.sv
// sirc_user_port_responder: controller-side SIRC endpoint serving parameter registers, input reads, output writes and the run flag.
// Define SIRC_RESP_STALL_EN to insert LFSR-driven 0-3 cycle stalls ahead of each channel Ack.
`timescale 1ns/1ps
module sirc_user_port_responder #(
    parameter int INMEM_BYTE_WIDTH     = 1,
    parameter int OUTMEM_BYTE_WIDTH    = 1,
    parameter int INMEM_ADDRESS_WIDTH  = 17,
    parameter int OUTMEM_ADDRESS_WIDTH = 13,
    parameter int INMEM_DEPTH          = 256,
    parameter int OUTMEM_DEPTH         = 64,
    parameter int REG_COUNT            = 8,
    parameter int READ_LATENCY         = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              hostRegWriteEn,
    input  logic [7:0]                        hostRegAddr,
    input  logic [31:0]                       hostRegData,
    input  logic                              hostInWriteEn,
    input  logic [INMEM_ADDRESS_WIDTH-1:0]    hostInAdd,
    input  logic [INMEM_BYTE_WIDTH*8-1:0]     hostInData,
    input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   hostOutReadAdd,
    output logic [OUTMEM_BYTE_WIDTH*8-1:0]    hostOutReadData,
    input  logic                              hostRunSet,
    output logic                              runDone,
    output logic                              rangeErr,
    output logic                              userRunValue,
    input  logic                              userRunClear,
    input  logic                              register32CmdReq,
    output logic                              register32CmdAck,
    input  logic [31:0]                       register32WriteData,
    input  logic [7:0]                        register32Address,
    input  logic                              register32WriteEn,
    output logic                              register32ReadDataValid,
    output logic [31:0]                       register32ReadData,
    input  logic                              inputMemoryReadReq,
    output logic                              inputMemoryReadAck,
    input  logic [INMEM_ADDRESS_WIDTH-1:0]    inputMemoryReadAdd,
    output logic                              inputMemoryReadDataValid,
    output logic [INMEM_BYTE_WIDTH*8-1:0]     inputMemoryReadData,
    input  logic                              outputMemoryWriteReq,
    output logic                              outputMemoryWriteAck,
    input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   outputMemoryWriteAdd,
    input  logic [OUTMEM_BYTE_WIDTH*8-1:0]    outputMemoryWriteData,
    input  logic [OUTMEM_BYTE_WIDTH-1:0]      outputMemoryWriteByteMask
);

    localparam int IN_W   = INMEM_BYTE_WIDTH * 8;
    localparam int OUT_W  = OUTMEM_BYTE_WIDTH * 8;
    localparam int REG_IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int IN_IW  = (INMEM_DEPTH > 1) ? $clog2(INMEM_DEPTH) : 1;
    localparam int OUT_IW = (OUTMEM_DEPTH > 1) ? $clog2(OUTMEM_DEPTH) : 1;

    logic [31:0]             r_regs    [REG_COUNT];
    logic [IN_W-1:0]         r_in_mem  [INMEM_DEPTH];
    logic [OUT_W-1:0]        r_out_mem [OUTMEM_DEPTH];

    logic                    r_reg_ack, r_in_ack, r_out_ack;
    logic [READ_LATENCY-1:0] r_reg_vld, r_in_vld;
    logic [31:0]             r_reg_dat [READ_LATENCY];
    logic [IN_W-1:0]         r_in_dat  [READ_LATENCY];
    logic                    r_range_err, r_run, r_run_done;
    logic [OUT_W-1:0]        r_host_rd;

    logic                    w_reg_acc, w_in_acc, w_out_acc;
    logic                    w_reg_ok, w_in_ok, w_out_ok;
    logic                    w_host_reg_ok, w_host_in_ok, w_host_out_ok;
    logic                    w_in_busy;
    logic [2:0]              w_elig, w_stall_ok;
    logic [31:0]             w_reg_rd_data;
    logic [IN_W-1:0]         w_in_rd_data;
    logic [OUT_IW-1:0]       w_out_idx;

    assign w_reg_acc = register32CmdReq & r_reg_ack;
    assign w_in_acc  = inputMemoryReadReq & r_in_ack;
    assign w_out_acc = outputMemoryWriteReq & r_out_ack;

    assign w_reg_ok      = 32'(register32Address) < 32'(REG_COUNT);
    assign w_in_ok       = 32'(inputMemoryReadAdd) < 32'(INMEM_DEPTH);
    assign w_out_ok      = 32'(outputMemoryWriteAdd) < 32'(OUTMEM_DEPTH);
    assign w_host_reg_ok = 32'(hostRegAddr) < 32'(REG_COUNT);
    assign w_host_in_ok  = 32'(hostInAdd) < 32'(INMEM_DEPTH);
    assign w_host_out_ok = 32'(hostOutReadAdd) < 32'(OUTMEM_DEPTH);
    assign w_out_idx     = outputMemoryWriteAdd[OUT_IW-1:0];

    assign w_reg_rd_data = w_reg_ok ? r_regs[register32Address[REG_IW-1:0]] : '0;
    assign w_in_rd_data  = w_in_ok ? r_in_mem[inputMemoryReadAdd[IN_IW-1:0]] : '0;

    // The input channel is free again in its DataValid cycle, i.e. once only the last stage holds the read.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_in_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            w_in_busy = w_in_busy | r_in_vld[i];
        end
    end

    assign w_elig = {outputMemoryWriteReq & ~r_out_ack,
                     inputMemoryReadReq & ~r_in_ack & ~w_in_busy,
                     register32CmdReq & ~r_reg_ack};

`ifdef SIRC_RESP_STALL_EN
    logic [15:0] r_lfsr;
    logic [1:0]  r_stall [3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
            for (int ch = 0; ch < 3; ch++) r_stall[ch] <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            for (int ch = 0; ch < 3; ch++) begin
                if (w_elig[ch]) begin
                    r_stall[ch] <= (r_stall[ch] == 2'd0) ? r_lfsr[2*ch +: 2] : r_stall[ch] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < 3; ch++) w_stall_ok[ch] = (r_stall[ch] == 2'd0);
    end
`else
    assign w_stall_ok = 3'b111;
`endif

    // NOTE: storage arrays are never reset; only handshake and status state is cleared.
    always_ff @(posedge clk) begin
        if (hostRegWriteEn && w_host_reg_ok) begin
            r_regs[hostRegAddr[REG_IW-1:0]] <= hostRegData;
        end
        if (w_reg_acc && register32WriteEn && w_reg_ok) begin
            r_regs[register32Address[REG_IW-1:0]] <= register32WriteData;
        end
        if (hostInWriteEn && w_host_in_ok) begin
            r_in_mem[hostInAdd[IN_IW-1:0]] <= hostInData;
        end
        if (w_out_acc && w_out_ok) begin
            for (int b = 0; b < OUTMEM_BYTE_WIDTH; b++) begin
                if (outputMemoryWriteByteMask[b]) begin
                    r_out_mem[w_out_idx][8*b +: 8] <= outputMemoryWriteData[8*b +: 8];
                end
            end
        end
        r_reg_dat[0] <= w_reg_rd_data;
        r_in_dat[0]  <= w_in_rd_data;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_reg_dat[i] <= r_reg_dat[i-1];
            r_in_dat[i]  <= r_in_dat[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_ack   <= 1'b0;
            r_in_ack    <= 1'b0;
            r_out_ack   <= 1'b0;
            r_reg_vld   <= '0;
            r_in_vld    <= '0;
            r_range_err <= 1'b0;
            r_run       <= 1'b0;
            r_run_done  <= 1'b0;
            r_host_rd   <= '0;
        end else begin
            r_reg_ack    <= w_elig[0] & w_stall_ok[0];
            r_in_ack     <= w_elig[1] & w_stall_ok[1];
            r_out_ack    <= w_elig[2] & w_stall_ok[2];
            r_reg_vld[0] <= w_reg_acc & ~register32WriteEn;
            r_in_vld[0]  <= w_in_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_reg_vld[i] <= r_reg_vld[i-1];
                r_in_vld[i]  <= r_in_vld[i-1];
            end
            if ((w_reg_acc & ~w_reg_ok) | (w_in_acc & ~w_in_ok) | (w_out_acc & ~w_out_ok)) begin
                r_range_err <= 1'b1;
            end
            // A set in the same cycle as a clear wins and suppresses runDone.
            r_run      <= hostRunSet | (r_run & ~userRunClear);
            r_run_done <= r_run & userRunClear & ~hostRunSet;
            r_host_rd  <= w_host_out_ok ? r_out_mem[hostOutReadAdd[OUT_IW-1:0]] : '0;
        end
    end

    assign register32CmdAck         = r_reg_ack;
    assign register32ReadDataValid  = r_reg_vld[READ_LATENCY-1];
    assign register32ReadData       = r_reg_vld[READ_LATENCY-1] ? r_reg_dat[READ_LATENCY-1] : '0;
    assign inputMemoryReadAck       = r_in_ack;
    assign inputMemoryReadDataValid = r_in_vld[READ_LATENCY-1];
    assign inputMemoryReadData      = r_in_vld[READ_LATENCY-1] ? r_in_dat[READ_LATENCY-1] : '0;
    assign outputMemoryWriteAck     = r_out_ack;
    assign hostOutReadData          = r_host_rd;
    assign rangeErr                 = r_range_err;
    assign userRunValue             = r_run;
    assign runDone                  = r_run_done;

endmodule
